current_pi_regulator: RTL
=========================

Name: current_pi_regulator

Overview:
- Dual PI current regulator directly downstream of the ADC/Clark/Park current path.
- Per control period: consumes measured Id/Iq and its completion pulse; produces voltage commands Ud/Uq for the inverse-Park/SVPWM stage.
- One shared 13x16 signed multiplier, time-multiplexed by an FSM over four products (Kp·ed, Ki·ed, Kp·eq, Ki·eq).
- Per-axis integrators with clamp anti-windup.

Parameters:
- OUT_LIM, 16'd12000: symmetric saturation magnitude for the integrators and outputs; legal range 1..32767.
- FRAC, 8: fractional bits of the Kp/Ki gains (Q8.8); product right-shift amount.

Ports:
- iClk  input  1  system clock
- iRst_n  input  1  reset, synchronous, active-low
- iEn  input  1  start pulse; connected to the current path's done pulse
- iClear  input  1  synchronous integrator clear
- iId_current  input  12  measured d-axis current, signed two's complement
- iIq_current  input  12  measured q-axis current, signed
- iId_ref  input  12  d-axis reference, signed
- iIq_ref  input  12  q-axis reference, signed
- iKp  input  16  proportional gain, unsigned Q8.8
- iKi  input  16  integral gain per period, unsigned Q8.8
- oUd  output  16  d-axis voltage command, signed
- oUq  output  16  q-axis voltage command, signed
- oBusy  output  1  high from accept through the done cycle
- oDone  output  1  one-cycle pulse; oUd/oUq updated

Behaviour:
- Clock and reset (already decided): single clock iClk; reset iRst_n is synchronous, active-low, sampled on the iClk rising edge.
- Reset values: oUd=0, oUq=0, oDone=0, oBusy=0, both integrators=0, FSM=IDLE.
- Reset asserted mid-sequence aborts the sequence; no oDone is produced.
- FSM states: IDLE, MPD, MID, MPQ, MIQ, ACC, OUT.
- IDLE, edge k with iEn=1:
  - latch ed=Id_ref−Id_current and eq=Iq_ref−Iq_current, each 13-bit signed with no overflow possible;
  - latch Kp and Ki;
  - go to MPD; oBusy=1 from the next cycle.
- Edges k+1..k+4 (MPD, MID, MPQ, MIQ): one product per state, in that order, each registered.
  - Product = sign-extended error × zero-extended gain (29-bit signed).
  - Then arithmetic shift right by FRAC, which floors toward −inf.
- Edge k+5 (ACC): each integrator becomes clamp(integ + Iterm, −OUT_LIM, +OUT_LIM).
  - Computed in at least 22-bit signed to avoid overflow.
  - Clamping the integrator is the anti-windup.
- Edge k+6 (OUT): oUd=clamp(Pd + integ_d), oUq=clamp(Pq + integ_q), clamp bounds ±OUT_LIM; oDone=1 for exactly one cycle; FSM returns to IDLE.
  - Latency: oDone is high in the cycle following edge k+6.
  - oBusy falls together with oDone.
- iEn while not in IDLE: ignored. No queuing.
- iEn in the same cycle that oDone is high: FSM is already in IDLE, so it is accepted. Back-to-back throughput is 1 sample per 7 cycles.
- iClear=1 on any edge forces both integrators to 0.
  - If this coincides with ACC, the clear wins and the Iterm is discarded.
  - Outputs are not cleared.
  - Does not affect FSM progress.
- Gains and inputs may change after acceptance without effect on the running sequence.
- Kp=0 and Ki=0 are legal.
  - Ki=0 freezes the integrators.
  - With Kp=0 and Ki=0 the output equals the held integrator.
- oUd/oUq hold their value between oDone pulses.

Test Plan:
- Reset then pulse iEn with Id_ref=100, Id=0, Iq_ref=Iq=0, Kp=0x0100, Ki=0x0040 -> oDone exactly 7 cycles after the iEn edge; oUd=125 (P 100 + I 25), oUq=0. Repeat the identical pulse -> oUd=150.
- Saturation: Id_ref=2047, Id=−2048, Kp=0x1000, Ki=0x1000 -> oUd=+12000, integ_d=+12000. Then ed=−100, Kp=0x0100, Ki=0x0100 -> integ_d=11900, oUd=11800 (anti-windup recovers immediately).
- Floor rounding: ed=−1, Kp=0, Ki=0x0040 -> Iterm=−1 per period; after 3 periods oUd=−3. Symmetric +1 case -> Iterm=0, oUd stays 0.
- iEn pulses at cycles 2 and 4 after acceptance -> ignored: single oDone, oBusy continuous. iEn coinciding with oDone -> second sequence runs, oDone 7 cycles later.
- iClear asserted in the ACC cycle with Id_ref=100 -> integ_d=0, oUd=100. iRst_n low at MID -> no oDone; all outputs and integrators 0 next cycle.
- Negative clamp: Iq_ref=−2048, Iq=2047, Kp=0x1000 -> oUq=−12000; oUd unaffected.

Source files
------------

// File: rtl/current_pi_regulator.sv
// Dual-axis PI current regulator: one shared multiplier sequenced over Kp*ed, Ki*ed, Kp*eq, Ki*eq,
// clamp anti-windup integrators and saturated Ud/Uq outputs, one sample per 7 cycles.
module current_pi_regulator #(
   parameter logic [15:0] OUT_LIM = 16'd12000,
   parameter int unsigned FRAC    = 8
) (
   input  logic               iClk,
   input  logic               iRst_n,
   input  logic               iEn,
   input  logic               iClear,
   input  logic [11:0]        iId_current,
   input  logic [11:0]        iIq_current,
   input  logic [11:0]        iId_ref,
   input  logic [11:0]        iIq_ref,
   input  logic [15:0]        iKp,
   input  logic [15:0]        iKi,
   output logic signed [15:0] oUd,
   output logic signed [15:0] oUq,
   output logic               oBusy,
   output logic               oDone
);

   localparam int unsigned ERR_W  = 13;
   localparam int unsigned GAIN_W = 16;
   localparam int unsigned PROD_W = 30;
   localparam int unsigned TERM_W = 21;
   localparam int unsigned SUM_W  = 22;
   localparam int unsigned OUT_W  = 16;

   localparam logic signed [SUM_W-1:0] LIM_P = $signed({6'd0, OUT_LIM});
   localparam logic signed [SUM_W-1:0] LIM_N = -LIM_P;

   typedef enum logic [2:0] {IDLE, MPD, MID, MPQ, MIQ, ACC, OUT} stateT;

   stateT                     state, stateN;
   logic signed [ERR_W-1:0]   errD, errDN, errQ, errQN;
   logic [GAIN_W-1:0]         kp, kpN, ki, kiN;
   logic signed [TERM_W-1:0]  pTermD, pTermDN, iTermD, iTermDN;
   logic signed [TERM_W-1:0]  pTermQ, pTermQN, iTermQ, iTermQN;
   logic signed [OUT_W-1:0]   integD, integDN, integQ, integQN;
   logic signed [OUT_W-1:0]   udN, uqN;
   logic                      busyN, doneN;

   logic signed [ERR_W-1:0]   mulErr;
   logic [GAIN_W-1:0]         mulGain;
   logic signed [PROD_W-1:0]  prodFull;
   logic signed [TERM_W-1:0]  prodShift;
   logic signed [SUM_W-1:0]   accD, accQ, sumD, sumQ;

   function automatic logic signed [OUT_W-1:0] clampLim(input logic signed [SUM_W-1:0] v);
      if (v > LIM_P)
         return OUT_W'(LIM_P);
      else if (v < LIM_N)
         return OUT_W'(LIM_N);
      else
         return OUT_W'(v);
   endfunction

   // Shared multiplier operand select; arithmetic shift floors toward -inf.
   always_comb begin
      mulErr  = errD;
      mulGain = kp;
      case (state)
         MID:     begin mulErr = errD; mulGain = ki; end
         MPQ:     begin mulErr = errQ; mulGain = kp; end
         MIQ:     begin mulErr = errQ; mulGain = ki; end
         default: begin mulErr = errD; mulGain = kp; end
      endcase
   end

   assign prodFull  = $signed({{(PROD_W-ERR_W){mulErr[ERR_W-1]}}, mulErr})
                    * $signed({{(PROD_W-GAIN_W){1'b0}}, mulGain});
   assign prodShift = TERM_W'(prodFull >>> FRAC);

   assign accD = $signed({{(SUM_W-OUT_W){integD[OUT_W-1]}}, integD})
               + $signed({{(SUM_W-TERM_W){iTermD[TERM_W-1]}}, iTermD});
   assign accQ = $signed({{(SUM_W-OUT_W){integQ[OUT_W-1]}}, integQ})
               + $signed({{(SUM_W-TERM_W){iTermQ[TERM_W-1]}}, iTermQ});
   assign sumD = $signed({{(SUM_W-TERM_W){pTermD[TERM_W-1]}}, pTermD})
               + $signed({{(SUM_W-OUT_W){integD[OUT_W-1]}}, integD});
   assign sumQ = $signed({{(SUM_W-TERM_W){pTermQ[TERM_W-1]}}, pTermQ})
               + $signed({{(SUM_W-OUT_W){integQ[OUT_W-1]}}, integQ});

   // Next-state and next-register values.
   always_comb begin
      stateN  = state;
      errDN   = errD;
      errQN   = errQ;
      kpN     = kp;
      kiN     = ki;
      pTermDN = pTermD;
      iTermDN = iTermD;
      pTermQN = pTermQ;
      iTermQN = iTermQ;
      integDN = integD;
      integQN = integQ;
      udN     = oUd;
      uqN     = oUq;
      busyN   = 1'b0;
      doneN   = 1'b0;
      case (state)
         IDLE: begin
            if (iEn) begin
               errDN  = $signed({iId_ref[11], iId_ref}) - $signed({iId_current[11], iId_current});
               errQN  = $signed({iIq_ref[11], iIq_ref}) - $signed({iIq_current[11], iIq_current});
               kpN    = iKp;
               kiN    = iKi;
               busyN  = 1'b1;
               stateN = MPD;
            end
         end
         MPD: begin pTermDN = prodShift; busyN = 1'b1; stateN = MID; end
         MID: begin iTermDN = prodShift; busyN = 1'b1; stateN = MPQ; end
         MPQ: begin pTermQN = prodShift; busyN = 1'b1; stateN = MIQ; end
         MIQ: begin iTermQN = prodShift; busyN = 1'b1; stateN = ACC; end
         ACC: begin
            integDN = clampLim(accD);
            integQN = clampLim(accQ);
            busyN   = 1'b1;
            stateN  = OUT;
         end
         OUT: begin
            udN    = clampLim(sumD);
            uqN    = clampLim(sumQ);
            doneN  = 1'b1;
            busyN  = 1'b1;
            stateN = IDLE;
         end
         default: stateN = IDLE;
      endcase
      if (iClear) begin
         integDN = '0;
         integQN = '0;
      end
   end

   always_ff @(posedge iClk) begin
      if (!iRst_n) begin
         state  <= IDLE;
         errD   <= '0;
         errQ   <= '0;
         kp     <= '0;
         ki     <= '0;
         pTermD <= '0;
         iTermD <= '0;
         pTermQ <= '0;
         iTermQ <= '0;
         integD <= '0;
         integQ <= '0;
         oUd    <= '0;
         oUq    <= '0;
         oBusy  <= 1'b0;
         oDone  <= 1'b0;
      end else begin
         state  <= stateN;
         errD   <= errDN;
         errQ   <= errQN;
         kp     <= kpN;
         ki     <= kiN;
         pTermD <= pTermDN;
         iTermD <= iTermDN;
         pTermQ <= pTermQN;
         iTermQ <= iTermQN;
         integD <= integDN;
         integQ <= integQN;
         oUd    <= udN;
         oUq    <= uqN;
         oBusy  <= busyN;
         oDone  <= doneN;
      end
   end

endmodule
